// File: rtl/delay_pkg.sv
// ---------------------------------------------------------------------------
// delay_pkg
// Shared definitions for the sample-delay FIFO sequencer and its datapath.
//   state_t      : sequencer state encoding, also exported on the state port
//   DEPTH / LW   : FIFO depth in samples and width of length/counter fields
//   ADC_OFFSET,
//   DAC_MID      : offset codes used by the datapath while the path is muted
// ---------------------------------------------------------------------------
package delay_pkg;

  localparam int DEPTH = 8192;
  localparam int LW    = 14;

  localparam logic [9:0] ADC_OFFSET = 10'h181;
  localparam logic [9:0] DAC_MID    = 10'h200;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/delay_line_ctrl_if.sv
// ---------------------------------------------------------------------------
// delay_line_ctrl_if
// Bundle between the delay-line sequencer and its environment (sample
// strobe source, length register, delay FIFO, DAC muting).
//   master : the sequencer (drives FIFO requests and status)
//   slave  : the environment (drives strobe, length and FIFO flags)
// Signals:
//   sample_en   one-cycle strobe per audio sample
//   delay_len   requested delay in samples
//   fifo_full   FIFO full flag
//   fifo_empty  FIFO empty flag
//   fifo_wrreq  FIFO write request
//   fifo_rdreq  FIFO read request
//   fifo_sclr   FIFO synchronous clear
//   out_valid   FIFO q holds a valid delayed sample
//   state       current sequencer state
//   err         sticky overflow/underflow flag
// ---------------------------------------------------------------------------
interface delay_line_ctrl_if #(
  parameter int LW = delay_pkg::LW
);
  import delay_pkg::*;

  logic          sample_en;
  logic [LW-1:0] delay_len;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_wrreq;
  logic          fifo_rdreq;
  logic          fifo_sclr;
  logic          out_valid;
  logic [1:0]    state;
  logic          err;

  modport master (
    input  sample_en,
    input  delay_len,
    input  fifo_full,
    input  fifo_empty,
    output fifo_wrreq,
    output fifo_rdreq,
    output fifo_sclr,
    output out_valid,
    output state,
    output err
  );

  modport slave (
    output sample_en,
    output delay_len,
    output fifo_full,
    output fifo_empty,
    input  fifo_wrreq,
    input  fifo_rdreq,
    input  fifo_sclr,
    input  out_valid,
    input  state,
    input  err
  );

endinterface

// File: rtl/delay_len_clamp.sv
// ---------------------------------------------------------------------------
// delay_len_clamp
// Combinational clamp of a requested delay into the range the FIFO can hold.
// A zero request becomes one sample; anything beyond DEPTH becomes DEPTH.
// Also used by the datapath for display/status of the effective delay.
//   delay_len  in  LW  requested delay in samples
//   len_c      out LW  effective delay in samples, 1..DEPTH
// ---------------------------------------------------------------------------
module delay_len_clamp #(
  parameter int DEPTH = delay_pkg::DEPTH,
  parameter int LW    = delay_pkg::LW
) (
  input  logic [LW-1:0] delay_len,
  output logic [LW-1:0] len_c
);
  import delay_pkg::*;

  localparam logic [LW-1:0] LEN_MIN = LW'(1);
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

  always_comb begin
    len_c = delay_len;
    if (delay_len == '0) begin
      len_c = LEN_MIN;
    end else if (delay_len > LEN_MAX) begin
      len_c = LEN_MAX;
    end
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// ---------------------------------------------------------------------------
// delay_line_ctrl
// Sequencer for the audio sample-delay FIFO. Clears the FIFO, primes it with
// exactly len samples, then runs it with one write/read pair per sample
// strobe so that the sample written on strobe k is read on strobe k+len.
// The DAC path is muted (out_valid low) whenever FIFO q is not a valid
// delayed sample. A change of the effective length restarts the sequence;
// FIFO overflow while priming or underflow while running also restarts it
// and sets a sticky error flag.
//
// Ports:
//   sysclk  in  system clock
//   rst_n   in  synchronous, active-low reset
//   bus     master side of delay_line_ctrl_if (strobe, length, FIFO
//           flags in; FIFO requests, out_valid, state, err out)
//
// state | meaning
// ------+-------------------------------------------------------------
// FLUSH | clear the FIFO for one cycle and latch the effective length
// FILL  | write strobed samples until len_q samples are held, no reads
// RUN   | one write and one read per strobe, delayed output valid
// ---------------------------------------------------------------------------
module delay_line_ctrl #(
  parameter int DEPTH = delay_pkg::DEPTH,
  parameter int LW    = delay_pkg::LW
) (
  input logic               sysclk,
  input logic               rst_n,
  delay_line_ctrl_if.master bus
);
  import delay_pkg::*;

  state_t        state_q;
  logic [LW-1:0] fill_cnt;
  logic [LW-1:0] len_q;
  logic          err_q;
  logic          out_valid_q;

  logic [LW-1:0] len_c;
  logic [LW-1:0] fill_inc;
  logic          in_flush;
  logic          in_fill;
  logic          in_run;
  logic          chg;
  logic          ovf;
  logic          udf;
  logic          wr;
  logic          rd;

  delay_len_clamp #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_clamp (
    .delay_len (bus.delay_len),
    .len_c     (len_c)
  );

  assign in_flush = (state_q == ST_FLUSH);
  assign in_fill  = (state_q == ST_FILL);
  assign in_run   = (state_q == ST_RUN);
  assign fill_inc = fill_cnt + LW'(1);

  // A length change outranks overflow/underflow: it restarts without
  // flagging an error, and suppresses any FIFO access on that cycle.
  assign chg = (in_fill | in_run) & (len_c != len_q);

  assign ovf = in_fill & bus.sample_en & bus.fifo_full
             & (fill_cnt < len_q) & ~chg;
  assign udf = in_run & bus.sample_en & bus.fifo_empty & ~chg;

  // In RUN a write while full is legal: the paired read frees the slot.
  assign wr = rst_n & bus.sample_en & ~chg
            & ((in_fill & ~bus.fifo_full) | (in_run & ~bus.fifo_empty));
  assign rd = rst_n & bus.sample_en & ~chg & in_run & ~bus.fifo_empty;

  // Requests are combinational so they line up with the strobed sample.
  assign bus.fifo_wrreq = wr;
  assign bus.fifo_rdreq = rd;
  assign bus.fifo_sclr  = rst_n & in_flush;
  assign bus.out_valid  = out_valid_q;
  assign bus.state      = state_q;
  assign bus.err        = err_q;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q     <= ST_FLUSH;
      fill_cnt    <= '0;
      len_q       <= LW'(1);
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          len_q       <= len_c;
          fill_cnt    <= '0;
          out_valid_q <= 1'b0;
          state_q     <= ST_FILL;
        end
        ST_FILL: begin
          out_valid_q <= 1'b0;
          if (chg) begin
            state_q <= ST_FLUSH;
          end else if (ovf) begin
            err_q   <= 1'b1;
            state_q <= ST_FLUSH;
          end else if (wr) begin
            fill_cnt <= fill_inc;
            if (fill_inc == len_q) begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (chg || udf) begin
            if (udf) begin
              err_q <= 1'b1;
            end
            out_valid_q <= 1'b0;
            state_q     <= ST_FLUSH;
          end else if (rd) begin
            // q becomes valid one cycle after the first read and then
            // holds between strobes.
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_FLUSH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_delay_line_ctrl
// Directed bench for delay_line_ctrl with a queue-based FIFO model driving
// the FIFO flags and q, a phase-level reference of the sequencing rules
// checked every cycle, and literal expectations at key points of each test.
// ---------------------------------------------------------------------------
module tb_delay_line_ctrl;
  localparam int DEPTH = 8192;
  localparam int LW    = 14;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 sysclk = ~sysclk;

  delay_line_ctrl_if #(.LW(LW)) dl_if ();

  delay_line_ctrl #(.DEPTH(DEPTH), .LW(LW)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (dl_if)
  );

  // FIFO model
  int   fq[$];
  int   q_reg      = 0;
  logic m_full     = 1'b0;
  logic m_empty    = 1'b1;
  logic force_full  = 1'b0;
  logic force_empty = 1'b0;
  logic cap_wr   = 1'b0;
  logic cap_rd   = 1'b0;
  logic cap_sclr = 1'b0;
  int   cap_wdata = 0;

  assign dl_if.fifo_full  = m_full | force_full;
  assign dl_if.fifo_empty = m_empty | force_empty;

  always @(posedge sysclk) begin
    if (cap_sclr) begin
      fq.delete();
    end else begin
      if (cap_rd && fq.size() > 0) q_reg <= fq.pop_front();
      if (cap_wr && fq.size() < DEPTH) fq.push_back(cap_wdata);
    end
    m_full  <= (fq.size() == DEPTH);
    m_empty <= (fq.size() == 0);
  end

  // counters and reference state
  int vectors = 0;
  int miscompares = 0;
  int sidx = 0;
  int cum_wr = 0, cum_rd = 0, cum_sclr = 0;
  bit check_en = 0;

  int m_phase = 0;   // 0 flush, 1 fill, 2 run
  int m_len   = 1;
  int m_need  = 0;
  bit m_err   = 0;
  bit m_valid = 0;
  bit pend    = 0;
  int pend_val = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor_step();
    int lenc;
    bit se, full, empty, chg, ovf, udf, ew, er, es;
    se    = dl_if.sample_en;
    full  = dl_if.fifo_full;
    empty = dl_if.fifo_empty;
    if (dl_if.delay_len == 0) lenc = 1;
    else if (int'(dl_if.delay_len) > DEPTH) lenc = DEPTH;
    else lenc = int'(dl_if.delay_len);
    chg = (m_phase != 0) && (lenc != m_len);
    ovf = (m_phase == 1) && se && full && !chg;
    udf = (m_phase == 2) && se && empty && !chg;
    ew  = rst_n && se && !chg && ((m_phase == 1 && !full) || (m_phase == 2 && !empty));
    er  = rst_n && se && !chg && (m_phase == 2) && !empty;
    es  = rst_n && (m_phase == 0);

    if (check_en) begin
      chk("state", int'(dl_if.state), m_phase);
      chk("wrreq", int'(dl_if.fifo_wrreq), int'(ew));
      chk("rdreq", int'(dl_if.fifo_rdreq), int'(er));
      chk("sclr", int'(dl_if.fifo_sclr), int'(es));
      chk("out_valid", int'(dl_if.out_valid), int'(m_valid));
      chk("err", int'(dl_if.err), int'(m_err));
      if (pend && dl_if.out_valid) chk("data", q_reg, pend_val);
    end
    pend     = er;
    pend_val = sidx - m_len;

    cap_wr    = dl_if.fifo_wrreq;
    cap_rd    = dl_if.fifo_rdreq;
    cap_sclr  = dl_if.fifo_sclr;
    cap_wdata = sidx;
    if (dl_if.fifo_wrreq) cum_wr++;
    if (dl_if.fifo_rdreq) cum_rd++;
    if (dl_if.fifo_sclr) cum_sclr++;
    if (se) sidx++;

    if (!rst_n) begin
      m_phase = 0; m_len = 1; m_need = 0; m_err = 0; m_valid = 0;
    end else begin
      case (m_phase)
        0: begin m_len = lenc; m_need = lenc; m_phase = 1; end
        1: begin
          if (chg) m_phase = 0;
          else if (ovf) begin m_err = 1; m_phase = 0; end
          else if (ew) begin
            m_need--;
            if (m_need == 0) m_phase = 2;
          end
        end
        default: begin
          if (chg || udf) begin
            if (udf) m_err = 1;
            m_phase = 0;
          end else if (er) m_valid = 1;
        end
      endcase
      if (m_phase != 2) m_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic strobes(input int n, input int per);
    for (int i = 0; i < n; i++) begin
      dl_if.sample_en = 1'b1;
      tick();
      dl_if.sample_en = 1'b0;
      for (int j = 1; j < per; j++) tick();
    end
  endtask

  int b_wr, b_rd, b_sc;

  initial begin
    dl_if.sample_en = 1'b0;
    dl_if.delay_len = 14'd4;
    fork
      forever begin
        @(negedge sysclk);
        monitor_step();
      end
    join_none

    // start-up, delay 4
    rst_n = 1'b0;
    tick();
    check_en = 1;
    @(negedge sysclk);
    chk("rst_state", int'(dl_if.state), 0);
    chk("rst_out_valid", int'(dl_if.out_valid), 0);
    chk("rst_err", int'(dl_if.err), 0);
    chk("rst_wrreq", int'(dl_if.fifo_wrreq), 0);
    tick(); tick();
    rst_n = 1'b1;
    b_wr = cum_wr; b_rd = cum_rd; b_sc = cum_sclr;
    @(negedge sysclk);
    chk("flush_sclr", int'(dl_if.fifo_sclr), 1);
    tick();
    strobes(4, 4);
    chk("start_sclr_cnt", cum_sclr - b_sc, 1);
    chk("start_writes", cum_wr - b_wr, 4);
    chk("start_reads", cum_rd - b_rd, 0);
    @(negedge sysclk);
    chk("start_run", int'(dl_if.state), 2);
    tick();
    dl_if.sample_en = 1'b1;
    @(negedge sysclk);
    chk("first_pair_wr", int'(dl_if.fifo_wrreq), 1);
    chk("first_pair_rd", int'(dl_if.fifo_rdreq), 1);
    tick();
    dl_if.sample_en = 1'b0;
    @(negedge sysclk);
    chk("first_valid", int'(dl_if.out_valid), 1);
    chk("first_data", q_reg, 0);
    tick();
    strobes(5, 4);

    // length change 4 -> 6 on a strobe
    dl_if.delay_len = 14'd6;
    dl_if.sample_en = 1'b1;
    @(negedge sysclk);
    chk("chg_wr", int'(dl_if.fifo_wrreq), 0);
    chk("chg_rd", int'(dl_if.fifo_rdreq), 0);
    tick();
    dl_if.sample_en = 1'b0;
    @(negedge sysclk);
    chk("chg_valid", int'(dl_if.out_valid), 0);
    chk("chg_state", int'(dl_if.state), 0);
    chk("chg_sclr", int'(dl_if.fifo_sclr), 1);
    b_wr = cum_wr; b_rd = cum_rd;
    tick();
    strobes(6, 4);
    chk("chg_writes", cum_wr - b_wr, 6);
    chk("chg_reads", cum_rd - b_rd, 0);
    chk("chg_run", int'(dl_if.state), 2);
    chk("chg_err", int'(dl_if.err), 0);
    strobes(4, 4);

    // underflow in RUN
    force_empty = 1'b1;
    dl_if.sample_en = 1'b1;
    @(negedge sysclk);
    chk("udf_wr", int'(dl_if.fifo_wrreq), 0);
    chk("udf_rd", int'(dl_if.fifo_rdreq), 0);
    tick();
    dl_if.sample_en = 1'b0;
    force_empty = 1'b0;
    @(negedge sysclk);
    chk("udf_err", int'(dl_if.err), 1);
    chk("udf_state", int'(dl_if.state), 0);
    tick();
    strobes(6, 4);
    chk("udf_refill_run", int'(dl_if.state), 2);
    chk("udf_err_sticky", int'(dl_if.err), 1);
    strobes(2, 4);

    // reset mid-RUN, also switches to delay 4
    rst_n = 1'b0;
    dl_if.delay_len = 14'd4;
    tick();
    rst_n = 1'b1;
    @(negedge sysclk);
    chk("mrst_state", int'(dl_if.state), 0);
    chk("mrst_valid", int'(dl_if.out_valid), 0);
    chk("mrst_err", int'(dl_if.err), 0);
    chk("mrst_sclr", int'(dl_if.fifo_sclr), 1);
    tick();

    // overflow in FILL at fill count 2
    strobes(2, 4);
    force_full = 1'b1;
    dl_if.sample_en = 1'b1;
    @(negedge sysclk);
    chk("ovf_wr", int'(dl_if.fifo_wrreq), 0);
    tick();
    dl_if.sample_en = 1'b0;
    force_full = 1'b0;
    @(negedge sysclk);
    chk("ovf_err", int'(dl_if.err), 1);
    chk("ovf_state", int'(dl_if.state), 0);
    tick();

    // clamp of zero length
    rst_n = 1'b0;
    dl_if.delay_len = 14'd0;
    tick();
    rst_n = 1'b1;
    tick();
    b_wr = cum_wr;
    strobes(1, 4);
    chk("len0_writes", cum_wr - b_wr, 1);
    chk("len0_run", int'(dl_if.state), 2);
    strobes(5, 3);

    // clamp of oversize length
    dl_if.delay_len = 14'd9000;
    tick();
    tick();
    b_wr = cum_wr; b_rd = cum_rd;
    strobes(8192, 2);
    chk("big_writes", cum_wr - b_wr, 8192);
    chk("big_reads", cum_rd - b_rd, 0);
    chk("big_run", int'(dl_if.state), 2);
    chk("big_full", int'(dl_if.fifo_full), 1);
    strobes(3, 2);
    chk("big_err", int'(dl_if.err), 0);
    chk("big_valid", int'(dl_if.out_valid), 1);
    chk("big_still_run", int'(dl_if.state), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
